// File: rtl/atm_pkg.sv
// Shared constants for the ATM card-session blocks: PIN entry states and keypad codes.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_HOLD    = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_DONE    = 3'd4,
        ST_EJECT   = 3'd5
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'h9;
    endfunction

    // Codes 0xD-0xF are dead keys: they neither act nor count as activity.
    function automatic logic is_known_key(input logic [3:0] code);
        return code <= KEY_ENTER;
    endfunction

endpackage

// File: rtl/pin_bcd2bin.sv
// Combinational 4-digit BCD to binary conversion (digit 0 in the low nibble).
module pin_bcd2bin (
    input  logic [15:0] bcd,
    output logic [13:0] bin
);

    // Inputs are well-formed BCD, so the sum never exceeds 9999 and fits 14 bits.
    assign bin = 14'(bcd[15:12]) * 14'd1000
               + 14'(bcd[11:8])  * 14'd100
               + 14'(bcd[7:4])   * 14'd10
               + 14'(bcd[3:0]);

endmodule

// File: rtl/pin_entry_unit.sv
// Keypad PIN collection for one card session: buffers BCD digits, hands the PIN
// to the verify controller, counts rejections and handles entry timeout / card return.
module pin_entry_unit
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_ATTEMPTS   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_inserted,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        pin_ack,
    input  logic        verify_ok,
    input  logic        verify_fail,
    output logic [15:0] pin_out,
    output logic        pin_valid,
    output logic [2:0]  digit_count,
    output logic        timeout,
    output logic        eject,
    output logic        locked
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    state_t          state_q, state_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   att_q, att_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [15:0]     pin_q, pin_d;
    logic            valid_q, valid_d;
    logic            tout_q, tout_d;
    logic            lock_q, lock_d;
    logic [13:0]     bin;

    pin_bcd2bin u_bcd2bin (
        .bcd (bcd_q),
        .bin (bin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            cnt_q   <= '0;
            att_q   <= '0;
            tmr_q   <= '0;
            pin_q   <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
            tmr_q   <= tmr_d;
            pin_q   <= pin_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        tmr_d   = tmr_q;
        pin_d   = pin_q;
        valid_d = valid_q;
        tout_d  = 1'b0;
        lock_d  = lock_q;

        // Card removal overrides every other event in every active state.
        if (state_q != ST_IDLE && !card_inserted) begin
            state_d = ST_IDLE;
            bcd_d   = '0;
            cnt_d   = '0;
            att_d   = '0;
            tmr_d   = '0;
            valid_d = 1'b0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (card_inserted) begin
                        state_d = ST_COLLECT;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        att_d   = '0;
                        tmr_d   = '0;
                    end
                end
                ST_COLLECT: begin
                    if (key_valid && is_known_key(key_code)) begin
                        tmr_d = '0;
                        if (is_digit(key_code)) begin
                            if (cnt_q < 3'(PIN_DIGITS)) begin
                                bcd_d = {bcd_q[11:0], key_code};
                                cnt_d = cnt_q + 3'd1;
                            end
                        end else if (key_code == KEY_BACK) begin
                            if (cnt_q != 3'd0) begin
                                bcd_d = {4'h0, bcd_q[15:4]};
                                cnt_d = cnt_q - 3'd1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            bcd_d = '0;
                            cnt_d = '0;
                        end else if (cnt_q == 3'(PIN_DIGITS)) begin
                            pin_d   = {2'b00, bin};
                            valid_d = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tout_d  = 1'b1;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        tmr_d   = '0;
                        lock_d  = 1'b0;
                        state_d = ST_EJECT;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (pin_ack) begin
                        valid_d = 1'b0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    // A simultaneous ok/fail pair is resolved as a rejection.
                    if (verify_fail) begin
                        att_d = att_q + AW'(1);
                        if (att_q == AW'(MAX_ATTEMPTS - 1)) begin
                            lock_d  = 1'b1;
                            state_d = ST_EJECT;
                        end else begin
                            bcd_d   = '0;
                            cnt_d   = '0;
                            tmr_d   = '0;
                            state_d = ST_COLLECT;
                        end
                    end else if (verify_ok) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE, ST_EJECT: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign pin_out     = pin_q;
    assign pin_valid   = valid_q;
    assign digit_count = cnt_q;
    assign timeout     = tout_q;
    assign eject       = (state_q == ST_EJECT);
    assign locked      = lock_q;

endmodule
